// File: rtl/mem_axi_bridge_pkg.sv
// Shared encodings and lane helpers for the MEM-side data-bus to AXI4 bridge
// and its lane-mapping sub-module.
package mem_axi_bridge_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_AR,
        ST_RD_R,
        ST_WR_AWW,
        ST_WR_B,
        ST_RESP
    } state_e;

    function automatic logic [7:0] size_strb(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 64'h0000_0000_0000_00FF;
            SIZE_H:  return 64'h0000_0000_0000_FFFF;
            SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] offset, input logic [1:0] size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_axi_bridge_lane.sv
// Byte-lane mapping between right-aligned CPU data and the 64-bit AXI data bus.
// Purely combinational; shared with the instruction-side bridge.
module mem_axi_lane
    import mem_axi_bridge_pkg::*;
(
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic [63:0] w_data_i,
    output logic [63:0] w_data_o,
    output logic [7:0]  w_strb_o,
    input  logic [63:0] r_data_i,
    output logic [63:0] r_data_o
);

    logic [5:0] shamt;

    assign shamt = {offset_i, 3'b000};

    always_comb begin
        w_data_o = w_data_i << shamt;
        w_strb_o = size_strb(size_i) << offset_i;
        r_data_o = (r_data_i >> shamt) & size_mask(size_i);
    end

endmodule

// File: rtl/mem_axi_bridge.sv
// MEM-stage data-bus responder issuing one single-beat AXI4 read or write per request.
// Optional response watchdog with late-beat draining: define MEM_AXI_TIMEOUT_EN.
module mem_axi_bridge
    import mem_axi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [DATA_W-1:0] mem_data_write_i,
    output logic [DATA_W-1:0] mem_data_read_o,
    output logic [1:0]        mem_resp_o,
    output logic              axi_aw_valid_o,
    input  logic              axi_aw_ready_i,
    output logic [ADDR_W-1:0] axi_aw_addr_o,
    output logic [2:0]        axi_aw_size_o,
    output logic              axi_w_valid_o,
    input  logic              axi_w_ready_i,
    output logic [DATA_W-1:0] axi_w_data_o,
    output logic [7:0]        axi_w_strb_o,
    output logic              axi_w_last_o,
    input  logic              axi_b_valid_i,
    output logic              axi_b_ready_o,
    input  logic [1:0]        axi_b_resp_i,
    output logic              axi_ar_valid_o,
    input  logic              axi_ar_ready_i,
    output logic [ADDR_W-1:0] axi_ar_addr_o,
    output logic [2:0]        axi_ar_size_o,
    input  logic              axi_r_valid_i,
    output logic              axi_r_ready_o,
    input  logic [DATA_W-1:0] axi_r_data_i,
    input  logic [1:0]        axi_r_resp_i,
    input  logic              axi_r_last_i
);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              misal_q, misal_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;

    logic              accept;
    logic              result_valid;
    logic [DATA_W-1:0] result_data;
    logic [1:0]        result_resp;
    logic [DATA_W-1:0] lane_w_data;
    logic [7:0]        lane_w_strb;
    logic [DATA_W-1:0] lane_r_data;
    logic              unused_inputs;

`ifdef MEM_AXI_TIMEOUT_EN
    localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYCLES);

    logic [9:0] tmo_q, tmo_d;
    logic       drain_q, drain_d;

    assign unused_inputs = axi_r_last_i;
`else
    assign unused_inputs = axi_r_last_i ^ TIMEOUT_CYCLES[0];
`endif

    mem_axi_lane u_lane (
        .offset_i (addr_q[2:0]),
        .size_i   (size_q),
        .w_data_i (wdata_q),
        .w_data_o (lane_w_data),
        .w_strb_o (lane_w_strb),
        .r_data_i (axi_r_data_i),
        .r_data_o (lane_r_data)
    );

    assign axi_ar_addr_o   = addr_q;
    assign axi_aw_addr_o   = addr_q;
    assign axi_ar_size_o   = {1'b0, size_q};
    assign axi_aw_size_o   = {1'b0, size_q};
    assign mem_data_read_o = rdata_q;
    assign mem_resp_o      = resp_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        req_d          = req_q;
        addr_d         = addr_q;
        size_d         = size_q;
        wdata_d        = wdata_q;
        misal_d        = misal_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        abort_d        = abort_q;
        rdata_d        = rdata_q;
        resp_d         = resp_q;
        result_valid   = 1'b0;
        result_data    = '0;
        result_resp    = RESP_OKAY;
        accept         = mem_valid_i;
        mem_ready_o    = 1'b0;
        axi_ar_valid_o = 1'b0;
        axi_r_ready_o  = 1'b0;
        axi_aw_valid_o = 1'b0;
        axi_w_valid_o  = 1'b0;
        axi_b_ready_o  = 1'b0;

`ifdef MEM_AXI_TIMEOUT_EN
        tmo_d   = '0;
        drain_d = drain_q;
        accept  = mem_valid_i && !drain_q;
        // A timed-out transaction still owes us one beat; swallow it before new traffic.
        if (drain_q) begin
            if (req_q == REQ_READ) begin
                axi_r_ready_o = 1'b1;
                if (axi_r_valid_i) drain_d = 1'b0;
            end else begin
                axi_b_ready_o = 1'b1;
                if (axi_b_valid_i) drain_d = 1'b0;
            end
        end
`endif

        if (state_q != ST_IDLE && !mem_valid_i) abort_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                abort_d   = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (accept) begin
                    req_d   = mem_req_i;
                    addr_d  = mem_addr_i;
                    size_d  = mem_size_i;
                    wdata_d = mem_data_write_i;
                    misal_d = misaligned(mem_addr_i[2:0], mem_size_i);
                    state_d = (mem_req_i == REQ_WRITE) ? ST_WR_AWW : ST_RD_AR;
                end
            end

            // Alignment is judged on the latched fields, so a rejected access
            // spends one cycle here with its AXI valids held low.
            ST_RD_AR: begin
                if (misal_q) begin
                    result_valid = 1'b1;
                    result_resp  = RESP_SLVERR;
                    state_d      = ST_RESP;
                end else begin
                    axi_ar_valid_o = 1'b1;
                    if (axi_ar_ready_i) state_d = ST_RD_R;
                end
            end

            ST_RD_R: begin
                axi_r_ready_o = 1'b1;
                if (axi_r_valid_i) begin
                    result_valid = 1'b1;
                    result_data  = lane_r_data;
                    result_resp  = axi_r_resp_i;
                    state_d      = ST_RESP;
                end
`ifdef MEM_AXI_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 10'd1;
                    if (tmo_d == TMO_LIMIT) begin
                        result_valid = 1'b1;
                        result_resp  = RESP_DECERR;
                        drain_d      = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
`endif
            end

            ST_WR_AWW: begin
                if (misal_q) begin
                    result_valid = 1'b1;
                    result_resp  = RESP_SLVERR;
                    state_d      = ST_RESP;
                end else begin
                    axi_aw_valid_o = !aw_done_q;
                    axi_w_valid_o  = !w_done_q;
                    aw_done_d      = aw_done_q | axi_aw_ready_i;
                    w_done_d       = w_done_q | axi_w_ready_i;
                    if (aw_done_d && w_done_d) state_d = ST_WR_B;
                end
            end

            ST_WR_B: begin
                axi_b_ready_o = 1'b1;
                if (axi_b_valid_i) begin
                    result_valid = 1'b1;
                    result_resp  = axi_b_resp_i;
                    state_d      = ST_RESP;
                end
`ifdef MEM_AXI_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 10'd1;
                    if (tmo_d == TMO_LIMIT) begin
                        result_valid = 1'b1;
                        result_resp  = RESP_DECERR;
                        drain_d      = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
`endif
            end

            ST_RESP: begin
                mem_ready_o = !abort_q;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        axi_w_last_o = axi_w_valid_o;
        axi_w_data_o = axi_w_valid_o ? lane_w_data : '0;
        axi_w_strb_o = axi_w_valid_o ? lane_w_strb : '0;

        // Abandoned requests must not disturb the last delivered result.
        if (result_valid && !abort_d) begin
            rdata_d = result_data;
            resp_d  = result_resp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            req_q     <= REQ_READ;
            addr_q    <= '0;
            size_q    <= SIZE_B;
            wdata_q   <= '0;
            misal_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            abort_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
`ifdef MEM_AXI_TIMEOUT_EN
            tmo_q     <= '0;
            drain_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            misal_q   <= misal_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            abort_q   <= abort_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
`ifdef MEM_AXI_TIMEOUT_EN
            tmo_q     <= tmo_d;
            drain_q   <= drain_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed scoreboard bench for mem_axi_bridge with a configurable AXI responder.
module tb_mem_axi_bridge;
    import mem_axi_bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_valid_i, mem_ready_o, mem_req_i;
    logic [63:0] mem_addr_i, mem_data_write_i, mem_data_read_o;
    logic [1:0]  mem_size_i, mem_resp_o;
    logic        axi_aw_valid_o, axi_aw_ready_i;
    logic [63:0] axi_aw_addr_o, axi_ar_addr_o, axi_w_data_o, axi_r_data_i;
    logic [2:0]  axi_aw_size_o, axi_ar_size_o;
    logic        axi_w_valid_o, axi_w_ready_i, axi_w_last_o;
    logic [7:0]  axi_w_strb_o;
    logic        axi_b_valid_i, axi_b_ready_o;
    logic [1:0]  axi_b_resp_i, axi_r_resp_i;
    logic        axi_ar_valid_o, axi_ar_ready_i;
    logic        axi_r_valid_i, axi_r_ready_o, axi_r_last_i;

    mem_axi_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_req_i(mem_req_i),
        .mem_addr_i(mem_addr_i), .mem_size_i(mem_size_i), .mem_data_write_i(mem_data_write_i),
        .mem_data_read_o(mem_data_read_o), .mem_resp_o(mem_resp_o),
        .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
        .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_size_o(axi_aw_size_o),
        .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
        .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
        .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o), .axi_b_resp_i(axi_b_resp_i),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
        .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_size_o(axi_ar_size_o),
        .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
        .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder configuration and observations.
    int          ar_dly, aw_dly, w_dly, r_dly;
    bit          r_en;
    logic [63:0] r_data_cfg;
    logic [1:0]  r_resp_cfg, b_resp_cfg;
    int          n_ar_cyc, n_aw_cyc, n_w_cyc, n_ready;
    logic [63:0] seen_ar_addr, seen_aw_addr, seen_w_data;
    logic [2:0]  seen_ar_size, seen_aw_size;
    logic [7:0]  seen_w_strb;
    logic        seen_w_last;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    int n_assert;
    int n_fail;

    // AXI responder: acts 2 time units after each rising edge.
    initial begin
        int c_ar, c_aw, c_w, c_r;
        bit ar_hs, aw_hs, w_hs, r_hs, b_hs, r_pend, b_pend, aw_got, w_got;
        c_ar = 0; c_aw = 0; c_w = 0; c_r = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        axi_ar_ready_i = 0; axi_aw_ready_i = 0; axi_w_ready_i = 0;
        axi_r_valid_i = 0; axi_r_data_i = '0; axi_r_resp_i = '0; axi_r_last_i = 0;
        axi_b_valid_i = 0; axi_b_resp_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                c_ar = 0; c_aw = 0; c_w = 0; c_r = 0;
                ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                axi_ar_ready_i = 0; axi_aw_ready_i = 0; axi_w_ready_i = 0;
                axi_r_valid_i = 0; axi_b_valid_i = 0;
                continue;
            end
            if (r_hs) r_pend = 0;
            if (b_hs) b_pend = 0;
            if (ar_hs) begin r_pend = 1; c_r = 0; end
            if (aw_hs) aw_got = 1;
            if (w_hs) w_got = 1;
            if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end

            if (axi_ar_valid_o) begin
                n_ar_cyc++; axi_ar_ready_i = (c_ar >= ar_dly); c_ar++;
            end else begin
                axi_ar_ready_i = 0; c_ar = 0;
            end
            if (axi_aw_valid_o) begin
                n_aw_cyc++; axi_aw_ready_i = (c_aw >= aw_dly); c_aw++;
            end else begin
                axi_aw_ready_i = 0; c_aw = 0;
            end
            if (axi_w_valid_o) begin
                n_w_cyc++; axi_w_ready_i = (c_w >= w_dly); c_w++;
            end else begin
                axi_w_ready_i = 0; c_w = 0;
            end

            axi_r_valid_i = r_pend && r_en && (c_r >= r_dly);
            if (r_pend && !axi_r_valid_i) c_r++;
            axi_r_data_i  = axi_r_valid_i ? r_data_cfg : '0;
            axi_r_resp_i  = axi_r_valid_i ? r_resp_cfg : '0;
            axi_r_last_i  = axi_r_valid_i;
            axi_b_valid_i = b_pend;
            axi_b_resp_i  = b_pend ? b_resp_cfg : '0;

            if (mem_ready_o) n_ready++;

            ar_hs = axi_ar_valid_o && axi_ar_ready_i;
            aw_hs = axi_aw_valid_o && axi_aw_ready_i;
            w_hs  = axi_w_valid_o && axi_w_ready_i;
            r_hs  = axi_r_valid_i && axi_r_ready_o;
            b_hs  = axi_b_valid_i && axi_b_ready_o;
            if (ar_hs) begin seen_ar_addr = axi_ar_addr_o; seen_ar_size = axi_ar_size_o; end
            if (aw_hs) begin seen_aw_addr = axi_aw_addr_o; seen_aw_size = axi_aw_size_o; end
            if (w_hs) begin
                seen_w_data = axi_w_data_o; seen_w_strb = axi_w_strb_o; seen_w_last = axi_w_last_o;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent byte-wise reference model.
    function automatic logic [63:0] model_rd(input logic [63:0] d, input logic [63:0] a, input logic [1:0] s);
        logic [63:0] r = '0;
        int off = int'(a[2:0]);
        for (int i = 0; i < (1 << s); i++)
            if (off + i < 8) r[8*i +: 8] = d[8*(off+i) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [63:0] a);
        logic [63:0] w = '0;
        int off = int'(a[2:0]);
        for (int i = 0; off + i < 8; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
        return w;
    endfunction

    function automatic logic [7:0] model_strb(input logic [63:0] a, input logic [1:0] s);
        logic [7:0] st = '0;
        int off = int'(a[2:0]);
        for (int i = 0; i < (1 << s); i++)
            if (off + i < 8) st[off+i] = 1'b1;
        return st;
    endfunction

    task automatic do_req(input string tag, input logic rq, input logic [63:0] addr,
                          input logic [1:0] size, input logic [63:0] wd,
                          input logic [63:0] exp_data, input logic [1:0] exp_resp, input int exp_lat);
        exp_t e;
        int   lat;
        sb.push_back('{data: exp_data, resp: exp_resp});
        mem_valid_i = 1; mem_req_i = rq; mem_addr_i = addr; mem_size_i = size; mem_data_write_i = wd;
        tick();
        mem_req_i = ~rq; mem_addr_i = ~addr; mem_size_i = ~size; mem_data_write_i = ~wd;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (mem_ready_o) begin lat = c; break; end
            tick();
        end
        e = sb.pop_front();
        if (lat < 0) begin
            check({tag, "_ready_seen"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_data"}, mem_data_read_o, e.data);
            check({tag, "_resp"}, 64'(mem_resp_o), 64'(e.resp));
            if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        end
        mem_valid_i = 0; mem_req_i = 0; mem_addr_i = '0; mem_size_i = '0; mem_data_write_i = '0;
        tick();
        check({tag, "_pulse_width"}, 64'(mem_ready_o), 64'd0);
        check({tag, "_hold"}, mem_data_read_o, e.data);
    endtask

    initial begin
        int snap;
        n_assert = 0; n_fail = 0;
        ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; r_en = 1;
        r_data_cfg = 64'h1122334455667788; r_resp_cfg = RESP_OKAY; b_resp_cfg = RESP_OKAY;
        n_ar_cyc = 0; n_aw_cyc = 0; n_w_cyc = 0; n_ready = 0;
        mem_valid_i = 0; mem_req_i = 0; mem_addr_i = '0; mem_size_i = '0; mem_data_write_i = '0;
        rst = 0;
        repeat (3) tick();
        check("rst_handshakes", 64'({axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o, axi_r_ready_o,
                                     axi_b_ready_o, mem_ready_o, axi_w_last_o}), 64'd0);
        check("rst_rdata", mem_data_read_o, 64'd0);
        check("rst_resp", 64'(mem_resp_o), 64'd0);
        check("rst_addrs", axi_ar_addr_o | axi_aw_addr_o, 64'd0);
        check("rst_wdata_strb", axi_w_data_o | 64'(axi_w_strb_o), 64'd0);
        rst = 1;
        tick();

        // Zero-wait doubleword read.
        n_ar_cyc = 0;
        do_req("rd_d", REQ_READ, 64'h80000008, SIZE_D, '0,
               model_rd(r_data_cfg, 64'h80000008, SIZE_D), RESP_OKAY, 3);
        check("rd_d_ar_addr", seen_ar_addr, 64'h80000008);
        check("rd_d_ar_size", 64'(seen_ar_size), 64'd3);
        check("rd_d_ar_cycles", 64'(n_ar_cyc), 64'd1);

        // Reset pulsed while waiting in RD_R.
        r_dly = 4;
        mem_valid_i = 1; mem_req_i = REQ_READ; mem_addr_i = 64'h80000005; mem_size_i = SIZE_B;
        tick(); tick();
        check("rstmid_in_rd_r", 64'(axi_r_ready_o), 64'd1);
        snap = n_ready;
        rst = 0;
        #1;
        check("rstmid_handshakes", 64'({axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o,
                                        axi_r_ready_o, axi_b_ready_o, mem_ready_o}), 64'd0);
        check("rstmid_rdata", mem_data_read_o, 64'd0);
        check("rstmid_addr", axi_ar_addr_o, 64'd0);
        mem_valid_i = 0; mem_addr_i = '0;
        tick(); tick();
        rst = 1;
        repeat (8) tick();
        check("rstmid_no_ready", 64'(n_ready), 64'(snap));
        check("rstmid_idle", 64'({axi_ar_valid_o, axi_r_ready_o}), 64'd0);

        // Byte read at offset 5 with wait states and DECERR.
        r_dly = 2; r_resp_cfg = RESP_DECERR;
        do_req("rd_b", REQ_READ, 64'h80000005, SIZE_B, '0,
               model_rd(r_data_cfg, 64'h80000005, SIZE_B), RESP_DECERR, 5);
        r_dly = 0; r_resp_cfg = RESP_OKAY;

        // Halfword write into the top lanes.
        do_req("wr_h", REQ_WRITE, 64'h80000006, SIZE_H, 64'h000000000000BEEF, '0, RESP_OKAY, 3);
        check("wr_h_strb", 64'(seen_w_strb), 64'(model_strb(64'h80000006, SIZE_H)));
        check("wr_h_wdata", seen_w_data, model_wdata(64'h000000000000BEEF, 64'h80000006));
        check("wr_h_aw", {seen_aw_addr[60:0], seen_aw_size}, {61'h80000006, 3'd1});
        check("wr_h_wlast", 64'(seen_w_last), 64'd1);

        // Misaligned accesses never reach AXI.
        n_ar_cyc = 0; n_aw_cyc = 0; n_w_cyc = 0;
        do_req("rd_mis", REQ_READ, 64'h80000002, SIZE_W, '0, '0, RESP_SLVERR, 2);
        do_req("wr_mis", REQ_WRITE, 64'h80000004, SIZE_D, 64'hFFFF, '0, RESP_SLVERR, 2);
        check("mis_no_axi", 64'(n_ar_cyc + n_aw_cyc + n_w_cyc), 64'd0);

        // AW stalled for 3 cycles, W accepted at once, SLVERR write response.
        aw_dly = 2; b_resp_cfg = RESP_SLVERR;
        n_aw_cyc = 0; n_w_cyc = 0; snap = n_ready;
        do_req("wr_awdly", REQ_WRITE, 64'h8000000C, SIZE_W, 64'hCAFEF00D12345678, '0, RESP_SLVERR, 5);
        check("wr_awdly_aw_cycles", 64'(n_aw_cyc), 64'd3);
        check("wr_awdly_w_cycles", 64'(n_w_cyc), 64'd1);
        check("wr_awdly_one_pulse", 64'(n_ready - snap), 64'd1);
        check("wr_awdly_strb", 64'(seen_w_strb), 64'(model_strb(64'h8000000C, SIZE_W)));
        check("wr_awdly_wdata", seen_w_data, model_wdata(64'hCAFEF00D12345678, 64'h8000000C));

        // AW and W both stalled one cycle, completing together.
        aw_dly = 1; w_dly = 1; b_resp_cfg = RESP_OKAY;
        do_req("wr_both", REQ_WRITE, 64'h80000003, SIZE_B, 64'h00000000000000A5, '0, RESP_OKAY, 4);
        check("wr_both_strb", 64'(seen_w_strb), 64'h08);
        check("wr_both_wdata", seen_w_data, 64'h00000000A5000000);
        aw_dly = 0; w_dly = 0;

        // Halfword read from the top lanes.
        do_req("rd_h", REQ_READ, 64'h8000000E, SIZE_H, '0,
               model_rd(r_data_cfg, 64'h8000000E, SIZE_H), RESP_OKAY, 3);

        // Initiator withdraws mid-read: AXI completes, no pulse, result kept.
        r_dly = 3; snap = n_ready;
        mem_valid_i = 1; mem_req_i = REQ_READ; mem_addr_i = 64'h80000000; mem_size_i = SIZE_D;
        tick(); tick();
        mem_valid_i = 0;
        repeat (10) tick();
        check("abort_no_ready", 64'(n_ready), 64'(snap));
        check("abort_data_kept", mem_data_read_o, 64'h1122);
        check("abort_idle", 64'(axi_r_ready_o), 64'd0);
        r_dly = 0; r_data_cfg = 64'h0102030405060708;
        do_req("rd_w_after", REQ_READ, 64'h80000004, SIZE_W, '0,
               model_rd(r_data_cfg, 64'h80000004, SIZE_W), RESP_OKAY, 3);

`ifdef MEM_AXI_TIMEOUT_EN
        // Read whose R beat arrives only after the watchdog fired.
        r_en = 0;
        do_req("rd_tmo", REQ_READ, 64'h80000010, SIZE_D, '0, '0, RESP_DECERR, 18);
        r_en = 1;
        do_req("rd_post_tmo", REQ_READ, 64'h80000010, SIZE_D, '0,
               model_rd(r_data_cfg, 64'h80000010, SIZE_D), RESP_OKAY, -1);
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
